simple_bus_arbiter: RTL
=======================

// Module: simple_bus_arbiter
// PURPOSE
//  Two-master arbiter and transaction sequencer in front of simple_bus.
//  Masters are m0 (CPU) and m1 (DMA); each issues single-beat read/write requests.
//  The arbiter grants one master, drives the shared bus for exactly one cycle and
//  returns captured read data with a one-cycle ready pulse.
//  Fair round-robin arbitration, with an optional lock that holds bounded bursts.
// PARAMETERS
//  ADDR_W     32  address width; drives simple_bus addr
//  DATA_W     32  data width for wdata/rdata
//  MAX_BURST  4   max consecutive locked beats per owner, >=1; 1 disables locking
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  m0_req      in   1       m0 request; held with addr/wdata/we until m0_ready
//  m0_addr     in   ADDR_W  m0 address
//  m0_wdata    in   DATA_W  m0 write data
//  m0_we       in   1       1=write, 0=read
//  m0_lock     in   1       request to keep ownership for the next beat
//  m0_ready    out  1       1-cycle pulse: beat complete
//  m0_rdata    out  DATA_W  read data; valid while m0_ready=1
//  m1_*        same set as m0_* for master 1
//  bus_addr    out  ADDR_W  to simple_bus addr
//  bus_wdata   out  DATA_W  to simple_bus wdata
//  bus_we      out  1       to simple_bus we
//  bus_re      out  1       to simple_bus re
//  bus_rdata   in   DATA_W  from simple_bus rdata (combinational decode)
//  owner       out  1       current or last granted master
//  busy        out  1       1 in ACCESS or RESP
// BEHAVIOUR
//  Reset values (rst=0, asynchronous):
//   - state=IDLE; all bus_*, m*_ready, m*_rdata, busy = 0
//   - owner=1, so m0 wins the first tie; burst_cnt=0
//  FSM, all outputs registered:
//   - IDLE: no req -> stay. Otherwise pick a winner, latch its addr/wdata/we -> ACCESS.
//   - ACCESS (1 cycle): bus_addr/bus_wdata = latched values; bus_we = we; bus_re = ~we.
//     bus_rdata is captured at the end of the cycle -> RESP.
//   - RESP (1 cycle): bus_* = 0; winner's m*_ready = 1; m*_rdata = captured data
//     (0 on writes); loser's ready/rdata = 0 -> IDLE.
//  Latency and throughput:
//   - req seen high in IDLE at edge N -> bus driven cycle N+1 -> ready cycle N+2.
//   - 3 cycles per beat minimum.
//  Arbitration in IDLE:
//   - Only one req -> grant it.
//   - Both req: grant ~owner (round robin), unless the lock is honoured.
//   - Lock honoured when owner's req and lock are high and burst_cnt < MAX_BURST-1.
//     The owner then keeps the grant and burst_cnt increments.
//   - Any grant to the other master, or with lock low, resets burst_cnt to 0.
//   - Lock is ignored when the other master is not requesting; no count limit then.
//  Bus idle value: bus_* = 0 outside ACCESS. Matches the decoder's unmapped or idle case.
//  Unmapped address: the beat completes normally; reads return 0 from the decoder.
//  Boundary conditions:
//   - req dropped during ACCESS/RESP: beat still completes and ready still pulses.
//   - Request fields change before ready: the latched copy is used; fields are not re-sampled.
//   - req high in the RESP cycle: not a new request; only IDLE samples req.
//   - Reset mid-beat: bus_* and ready drop immediately; the beat is lost and must be re-issued.
//   - MAX_BURST=1: lock never honoured.
// STRUCTURE
//  Shared include simple_bus_defs.vh, constants:
//   - state encodings ST_IDLE/ST_ACCESS/ST_RESP (2 bits)
//   - owner encodings M_CPU=0, M_DMA=1
//   - region bases GPIO_BASE=16'h1000, PWM_BASE=16'h2000 for benches and decoder
//  One sub-module, rr_arb2: combinational 2-way round-robin picker with lock.
//   - Inputs: req[1:0], last owner, lock_ok.
//   - Outputs: grant_valid, grant_idx.
//  The FSM, latches and burst counter stay in the top module.
// TESTING
//  1. Reset: rst=0 while m0_req=1 -> all bus_*, ready and busy stay 0. Release -> owner=0 wins first.
//  2. m0 write 0x1000_0004 <= 0xA5 -> bus_we=1 exactly one cycle, 1 cycle after req.
//     m0_ready pulses on the next cycle.
//  3. m1 read 0x2000_0008, bus_rdata=0x1234 -> m1_rdata=0x1234 with m1_ready.
//     bus_re=1 for one cycle.
//  4. m0 and m1 both requesting continuously, no lock -> grants alternate 0,1,0,1.
//     Each ready is 3 cycles apart.
//  5. Both requesting, m0_lock=1, MAX_BURST=4 -> four m0 beats, then one m1 beat, then m0 again.
//  6. rst=0 asserted during ACCESS -> bus_we drops asynchronously and no ready pulse.
//     After release, the re-issued beat completes normally.

Source files
------------

// File: rtl/simple_bus_arbiter_pkg.sv
// Shared constants and types for the two-master simple_bus arbiter.
// Holds the FSM state encoding, the master indices and the decoder region bases.
package simple_bus_arbiter_pkg;

    // Arbiter sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // Master indices: CPU is master 0, DMA is master 1
    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    // Upper-halfword region bases seen by the simple_bus decoder
    localparam logic [15:0] GPIO_BASE = 16'h1000;
    localparam logic [15:0] PWM_BASE  = 16'h2000;

endpackage

// File: rtl/simple_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// With both masters requesting, the last owner keeps the grant only when lock_ok
// is set; otherwise the other master wins. A lone requester always wins.
module rr_arb2
    import simple_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       lock_ok,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pick a winner from the request pair, favouring the master that did not go last
    always_comb begin
        grant_valid = |req;
        grant_idx   = last_owner;
        case (req)
            2'b01:   grant_idx = M_CPU;
            2'b10:   grant_idx = M_DMA;
            2'b11:   grant_idx = lock_ok ? last_owner : ~last_owner;
            default: grant_idx = last_owner;
        endcase
    end

endmodule

// File: rtl/simple_bus_arbiter.sv
// Two-master arbiter and single-beat transaction sequencer in front of simple_bus.
// IDLE picks a winner and latches its request onto the bus registers, ACCESS drives
// the bus for one cycle and captures read data, RESP pulses the winner's ready.
// A bounded lock lets the current owner keep the bus for up to MAX_BURST beats.
module simple_bus_arbiter
    import simple_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    input  logic              m0_lock,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    input  logic              m1_lock,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              owner,
    output logic              busy
);

    // The counter only needs to reach MAX_BURST-1; with MAX_BURST=1 the limit is 0
    // and the "< limit" test below can never pass, so locking is disabled.
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST - 1);

    // Per-master request views so the grant index can select fields directly
    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [1:0]        lock_vec;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];

    assign req_vec      = {m1_req,  m0_req};
    assign we_vec       = {m1_we,   m0_we};
    assign lock_vec     = {m1_lock, m0_lock};
    assign addr_arr[0]  = m0_addr;
    assign addr_arr[1]  = m1_addr;
    assign wdata_arr[0] = m0_wdata;
    assign wdata_arr[1] = m1_wdata;

    // Sequencer state and registered outputs
    arb_state_t        state_reg;
    logic              owner_reg;
    logic [BURST_W-1:0] burst_cnt_reg;
    logic [ADDR_W-1:0] bus_addr_reg;
    logic [DATA_W-1:0] bus_wdata_reg;
    logic              bus_we_reg;
    logic              bus_re_reg;
    logic [1:0]        ready_reg;
    logic [DATA_W-1:0] rdata_reg [2];
    logic              busy_reg;

    // Arbitration
    logic lock_ok;
    logic lock_honoured;
    logic grant_valid;
    logic grant_idx;
    logic [BURST_W-1:0] burst_cnt_next;

    // Owner may keep the bus only while its lock is up and the burst budget remains
    assign lock_ok        = lock_vec[owner_reg] && (burst_cnt_reg < BURST_LIMIT);
    // The lock only matters when both masters compete; otherwise it is ignored
    assign lock_honoured  = (&req_vec) && lock_ok;
    assign burst_cnt_next = lock_honoured ? (burst_cnt_reg + BURST_W'(1)) : '0;

    rr_arb2 u_rr_arb2 (
        .req         (req_vec),
        .last_owner  (owner_reg),
        .lock_ok     (lock_ok),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Beat sequencer: grant in IDLE, drive bus in ACCESS, return ready/rdata in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= M_DMA;
            burst_cnt_reg <= '0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_we_reg    <= 1'b0;
            bus_re_reg    <= 1'b0;
            ready_reg     <= '0;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        // Latch the winner's request; later changes on its inputs are ignored
                        state_reg     <= ST_ACCESS;
                        owner_reg     <= grant_idx;
                        burst_cnt_reg <= burst_cnt_next;
                        bus_addr_reg  <= addr_arr[grant_idx];
                        bus_wdata_reg <= wdata_arr[grant_idx];
                        bus_we_reg    <= we_vec[grant_idx];
                        bus_re_reg    <= ~we_vec[grant_idx];
                        busy_reg      <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // Bus returns to its idle value; decoder output is captured now
                    state_reg            <= ST_RESP;
                    bus_addr_reg         <= '0;
                    bus_wdata_reg        <= '0;
                    bus_we_reg           <= 1'b0;
                    bus_re_reg           <= 1'b0;
                    ready_reg[owner_reg] <= 1'b1;
                    rdata_reg[owner_reg] <= bus_we_reg ? '0 : bus_rdata;
                end
                ST_RESP: begin
                    state_reg    <= ST_IDLE;
                    ready_reg    <= '0;
                    rdata_reg[0] <= '0;
                    rdata_reg[1] <= '0;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    bus_addr_reg  <= '0;
                    bus_wdata_reg <= '0;
                    bus_we_reg    <= 1'b0;
                    bus_re_reg    <= 1'b0;
                    ready_reg     <= '0;
                    rdata_reg[0]  <= '0;
                    rdata_reg[1]  <= '0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_we    = bus_we_reg;
    assign bus_re    = bus_re_reg;
    assign m0_ready  = ready_reg[0];
    assign m1_ready  = ready_reg[1];
    assign m0_rdata  = rdata_reg[0];
    assign m1_rdata  = rdata_reg[1];
    assign owner     = owner_reg;
    assign busy      = busy_reg;

endmodule
